// File: rtl/unmask_pkg.sv
// -----------------------------------------------------------------------------
// unmask_pkg
//   Definitions shared by the masked 256-bit state register and its
//   receive-side deserialiser (unmask_deser):
//     - WIDTH_DEF / BEAT_W_DEF : default word and beat widths
//     - MASK_DEF               : XOR mask; also the masking register's
//                                reset/clear value, so both sides agree
//     - deser_state_t          : deserialiser FSM states
// -----------------------------------------------------------------------------
package unmask_pkg;

    localparam int WIDTH_DEF  = 256;
    localparam int BEAT_W_DEF = 32;

    // Top 16 bits set, everything else clear.
    localparam logic [WIDTH_DEF-1:0] MASK_DEF = {16'hFFFF, {(WIDTH_DEF-16){1'b0}}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } deser_state_t;

endpackage

// File: rtl/beat_shift_reg.sv
// -----------------------------------------------------------------------------
// beat_shift_reg
//   BEAT_W-in / WIDTH-wide shift register. Each load shifts the register left
//   by BEAT_W and inserts din into the LSBs, so after a full word the first
//   beat sits in the MSBs.
//
//   Ports:
//     clk     : rising-edge clock
//     reset   : asynchronous active-low reset, clears the register
//     clr     : discard current contents (combined with load, restarts the
//               register with din as its only beat)
//     load    : shift din in
//     din     : beat payload
//     q_next  : value the register takes at the next edge; lets the owner
//               register the completed word in the same cycle as the last beat
// -----------------------------------------------------------------------------
module beat_shift_reg #(
    parameter int WIDTH  = 256,
    parameter int BEAT_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              load,
    input  logic [BEAT_W-1:0] din,
    output logic [WIDTH-1:0]  q_next
);

    logic [WIDTH-1:0] q;

    always_comb begin
        // NOTE: every always_comb output gets a default before any branch so
        // no path leaves it unassigned, which would infer a latch.
        q_next = q;
        if (clr && load) begin
            q_next = WIDTH'(din);
        end else if (clr) begin
            q_next = '0;
        end else if (load) begin
            q_next = (q << BEAT_W) | WIDTH'(din);
        end
    end

    // NOTE: sequential state is written with non-blocking assignments only,
    // so every flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else begin
            q <= q_next;
        end
    end

endmodule

// File: rtl/unmask_deser.sv
// -----------------------------------------------------------------------------
// unmask_deser
//   Reassembles a masked WIDTH-bit word from BEAT_W-bit beats and optionally
//   strips MASK by XOR before presenting it on a WIDTH-bit valid/ready port.
//
//   Ports:
//     clk        : rising-edge clock
//     reset      : asynchronous active-low reset
//     in_valid   : beat valid
//     in_ready   : beat accepted when in_valid && in_ready (low in HOLD)
//     in_data    : beat payload, first beat of a word is the MSB beat
//     in_last    : final beat of a word
//     unmask_en  : sampled on a word's first beat; 1 = XOR MASK into output
//     out_valid  : recovered word valid
//     out_ready  : consumer accepts the word
//     out_data   : recovered word, stable while out_valid && !out_ready
//     frame_err  : sticky framing error
//     err_clr    : synchronous clear of frame_err (a new error wins)
// -----------------------------------------------------------------------------
module unmask_deser
    import unmask_pkg::*;
#(
    parameter int              WIDTH  = WIDTH_DEF,   // multiple of BEAT_W
    parameter int              BEAT_W = BEAT_W_DEF,
    parameter logic [WIDTH-1:0] MASK  = MASK_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BEAT_W-1:0] in_data,
    input  logic              in_last,
    input  logic              unmask_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic              frame_err,
    input  logic              err_clr
);

    localparam int BEATS = WIDTH / BEAT_W;
    localparam int CNT_W = $clog2(BEATS + 1);

    deser_state_t     state;
    logic [CNT_W-1:0] count;
    logic             mode_q;

    logic             accept;
    logic             first;
    logic [CNT_W-1:0] base_cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             word_full;
    logic             short_frame;
    logic             mode_eff;
    logic             err_set;
    logic             sr_clr;
    logic             sr_load;
    logic [WIDTH-1:0] word_next;

    // A beat seen in IDLE starts a fresh word: the count restarts and the
    // shift register is cleared and loaded in one step.
    always_comb begin
        accept      = 1'b0;
        first       = 1'b0;
        base_cnt    = '0;
        cnt_inc     = '0;
        word_full   = 1'b0;
        short_frame = 1'b0;
        mode_eff    = 1'b0;
        err_set     = 1'b0;
        sr_clr      = 1'b0;
        sr_load     = 1'b0;

        accept      = in_valid && in_ready;
        first       = (state == IDLE);
        base_cnt    = first ? '0 : count;
        cnt_inc     = base_cnt + 1'b1;
        word_full   = accept && (cnt_inc == CNT_W'(BEATS));
        short_frame = accept && in_last && !word_full;
        mode_eff    = first ? unmask_en : mode_q;

        // Early in_last drops the word; a missing in_last on the final beat
        // is flagged but the word is still delivered.
        err_set     = short_frame || (word_full && !in_last);

        sr_load     = accept && !short_frame;
        sr_clr      = (accept && first) || short_frame ||
                      ((state == HOLD) && out_ready);
    end

    beat_shift_reg #(
        .WIDTH  (WIDTH),
        .BEAT_W (BEAT_W)
    ) u_shift (
        .clk    (clk),
        .reset  (reset),
        .clr    (sr_clr),
        .load   (sr_load),
        .din    (in_data),
        .q_next (word_next)
    );

    // in_ready is registered from the next state, so it is low during reset,
    // rises on the first edge after release, and rises on the same edge that
    // leaves HOLD (no same-cycle bypass from out handshake to in handshake).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            count     <= '0;
            mode_q    <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            frame_err <= 1'b0;
        end else begin
            if (err_set) begin
                frame_err <= 1'b1;
            end else if (err_clr) begin
                frame_err <= 1'b0;
            end

            case (state)
                IDLE, COLLECT: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        if (first) begin
                            mode_q <= unmask_en;
                        end
                        if (word_full) begin
                            state     <= HOLD;
                            count     <= cnt_inc;
                            out_data  <= word_next ^ (mode_eff ? MASK : '0);
                            out_valid <= 1'b1;
                            in_ready  <= 1'b0;
                        end else if (short_frame) begin
                            state <= IDLE;
                            count <= '0;
                        end else begin
                            state <= COLLECT;
                            count <= cnt_inc;
                        end
                    end
                end

                HOLD: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        count     <= '0;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end

                default: begin
                    state     <= IDLE;
                    count     <= '0;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_unmask_deser.sv
// -----------------------------------------------------------------------------
// tb_unmask_deser
//   Directed bench for unmask_deser. Inputs change and outputs are sampled on
//   the falling edge; the DUT acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_unmask_deser;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         in_last;
    logic         unmask_en;
    logic         out_valid;
    logic         out_ready;
    logic [255:0] out_data;
    logic         frame_err;
    logic         err_clr;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    unmask_deser dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .unmask_en (unmask_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .frame_err (frame_err),
        .err_clr   (err_clr)
    );

    task automatic check(input string tag, input logic [255:0] observed,
                         input logic [255:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the beat
    // was accepted.
    task automatic send_beat(input logic [31:0] d, input logic last, input logic en);
        int waited = 0;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("in_ready_wait", 256'(in_ready), 256'(1));
        in_valid  = 1'b1;
        in_data   = d;
        in_last   = last;
        unmask_en = en;
        @(negedge clk);
        in_valid  = 1'b0;
        in_last   = 1'b0;
        unmask_en = 1'b0;
        in_data   = '0;
    endtask

    // Sends the first n beats of w (MSB beat first); in_last on beat n if set.
    task automatic send_word(input logic [255:0] w, input logic en, input int n,
                             input logic last_on_n);
        for (int i = 0; i < n; i++) begin
            send_beat(w[255-32*i -: 32], (i == n - 1) && last_on_n, en);
        end
    endtask

    task automatic take_word(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, 256'(out_valid), 256'(0));
        check({tag, "_ready_rise"}, 256'(in_ready), 256'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] held;

        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        unmask_en = 1'b0;
        out_ready = 1'b0;
        err_clr   = 1'b0;

        // Reset state
        #2;
        check("rst_in_ready",  256'(in_ready),  256'(0));
        check("rst_out_valid", 256'(out_valid), 256'(0));
        check("rst_out_data",  out_data,        256'(0));
        check("rst_frame_err", 256'(frame_err), 256'(0));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 256'(in_ready), 256'(1));

        // 1: masked word with unmask -> all zero, 1-cycle latency
        send_word({32'hFFFF0000, 224'h0}, 1'b1, 8, 1'b1);
        check("w1_valid",     256'(out_valid), 256'(1));
        check("w1_data",      out_data,        256'(0));
        check("w1_frame_err", 256'(frame_err), 256'(0));
        check("w1_in_ready",  256'(in_ready),  256'(0));
        take_word("w1");

        // 2: same beats, mask retained
        send_word({32'hFFFF0000, 224'h0}, 1'b0, 8, 1'b1);
        check("w2_valid", 256'(out_valid), 256'(1));
        check("w2_data",  out_data,        {32'hFFFF0000, 224'h0});
        take_word("w2");

        // 3: backpressure, output held, beat 9 waits for the out handshake
        send_word(256'h00000001_00000002_00000003_00000004_00000005_00000006_00000007_00000008,
                  1'b1, 8, 1'b1);
        held = 256'hFFFF0001_00000002_00000003_00000004_00000005_00000006_00000007_00000008;
        check("w3_data", out_data, held);
        in_valid  = 1'b1;
        in_data   = 32'h00000009;
        in_last   = 1'b0;
        unmask_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("w3_hold_valid",    256'(out_valid), 256'(1));
            check("w3_hold_data",     out_data,        held);
            check("w3_hold_in_ready", 256'(in_ready),  256'(0));
        end
        take_word("w3");
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = '0;
        for (int i = 10; i <= 16; i++) begin
            send_beat(32'(i), i == 16, 1'b0);
        end
        check("w3b_valid", 256'(out_valid), 256'(1));
        check("w3b_data", out_data,
              256'h00000009_0000000A_0000000B_0000000C_0000000D_0000000E_0000000F_00000010);
        check("w3_frame_err", 256'(frame_err), 256'(0));
        take_word("w3b");

        // 4: short frame (in_last on beat 3), then a clean word
        send_word({32'hBAD00001, 32'hBAD00002, 32'hBAD00003, 160'h0}, 1'b1, 3, 1'b1);
        check("short3_err",      256'(frame_err), 256'(1));
        check("short3_no_valid", 256'(out_valid), 256'(0));
        check("short3_in_ready", 256'(in_ready),  256'(1));
        @(negedge clk);
        check("short3_still_no_valid", 256'(out_valid), 256'(0));
        send_word({8{32'h11111111}}, 1'b1, 8, 1'b1);
        check("w4_valid",      256'(out_valid), 256'(1));
        check("w4_data",       out_data,        {32'hEEEE1111, {7{32'h11111111}}});
        check("w4_err_sticky", 256'(frame_err), 256'(1));
        take_word("w4");
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("w4_err_cleared", 256'(frame_err), 256'(0));

        // 5: asynchronous reset after beat 5 discards the partial word
        send_word({8{32'h12345678}}, 1'b0, 5, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check("arst_in_ready",  256'(in_ready),  256'(0));
        check("arst_out_valid", 256'(out_valid), 256'(0));
        check("arst_out_data",  out_data,        256'(0));
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        send_word({8{32'hA5A5A5A5}}, 1'b1, 8, 1'b1);
        check("w5_valid",     256'(out_valid), 256'(1));
        check("w5_data",      out_data,        {32'h5A5AA5A5, {7{32'hA5A5A5A5}}});
        check("w5_frame_err", 256'(frame_err), 256'(0));
        take_word("w5");

        // 6: missing in_last on beat 8 -> delivered with error
        send_word(256'hC0DE0001_C0DE0002_C0DE0003_C0DE0004_C0DE0005_C0DE0006_C0DE0007_C0DE0008,
                  1'b0, 8, 1'b0);
        check("w6_valid", 256'(out_valid), 256'(1));
        check("w6_data", out_data,
              256'hC0DE0001_C0DE0002_C0DE0003_C0DE0004_C0DE0005_C0DE0006_C0DE0007_C0DE0008);
        check("w6_frame_err", 256'(frame_err), 256'(1));
        take_word("w6");

        // err_clr coincides with a new short-frame error: error wins
        send_beat(32'h00000001, 1'b0, 1'b0);
        err_clr = 1'b1;
        send_beat(32'h00000002, 1'b1, 1'b0);
        err_clr = 1'b0;
        check("clr_vs_err",      256'(frame_err), 256'(1));
        check("clr_vs_err_nout", 256'(out_valid), 256'(0));
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("err_clear2", 256'(frame_err), 256'(0));

        // in_last on the very first beat is a short frame too
        send_beat(32'hFEEDFACE, 1'b1, 1'b1);
        check("short1_err",      256'(frame_err), 256'(1));
        check("short1_no_valid", 256'(out_valid), 256'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
